// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: LSB-first bit stream with start marker in,
// WIDTH-bit word with valid/ready out. Define SERIAL_WORD_RX_PARITY_EN for the even-parity build.
module serial_word_rx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I,
  input  logic             I_valid,
  input  logic             I_start,
  output logic             I_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             O_ferr,
  output logic             O_perr
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef SERIAL_WORD_RX_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif
  localparam logic [1:0] ST_HOLD   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             ferr_q, ferr_d;
`ifdef SERIAL_WORD_RX_PARITY_EN
  logic             perr_q, perr_d;
`endif
  logic             bit_acc;

  assign I_ready = (state_q != ST_HOLD);
  assign O_valid = (state_q == ST_HOLD);
  assign bit_acc = I_valid && I_ready;
  assign O       = word_q;
  assign O_ferr  = ferr_q;
`ifdef SERIAL_WORD_RX_PARITY_EN
  assign O_perr  = perr_q;
`else
  assign O_perr  = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    ferr_d  = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Non-start bits arriving between words are dropped silently.
        if (bit_acc && I_start) begin
          word_d    = '0;
          word_d[0] = I;
          cnt_d     = CNT_W'(1);
          state_d   = ST_SHIFT;
`ifdef SERIAL_WORD_RX_PARITY_EN
          perr_d    = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        if (bit_acc) begin
          if (I_start) begin
            // Premature start: flag it and restart the word from this bit.
            ferr_d    = 1'b1;
            word_d    = '0;
            word_d[0] = I;
            cnt_d     = CNT_W'(1);
          end else begin
            for (int k = 0; k < WIDTH; k++) begin
              if (cnt_q == CNT_W'(k)) word_d[k] = I;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(WIDTH)) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_HOLD;
`endif
            end
          end
        end
      end
`ifdef SERIAL_WORD_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_acc) begin
          state_d = ST_HOLD;
          if (I_start) begin
            ferr_d = 1'b1;
            perr_d = 1'b1;
          end else begin
            perr_d = (^word_q) ^ I;
          end
        end
      end
`endif
      ST_HOLD: begin
        if (O_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      ferr_q  <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      ferr_q  <= ferr_d;
`ifdef SERIAL_WORD_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx: directed vector table, hand-written
// hold/reset sequences, then random traffic against a queue-based reference model.
module tb_serial_word_rx;

  localparam int WIDTH = 8;
`ifdef SERIAL_WORD_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             CLK;
  logic             ASYNCRESETN;
  logic             I, I_valid, I_start, I_ready;
  logic [WIDTH-1:0] O;
  logic             O_valid, O_ready, O_ferr, O_perr;

  int checks = 0;
  int errors = 0;

  serial_word_rx #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I(I), .I_valid(I_valid), .I_start(I_start), .I_ready(I_ready),
    .O(O), .O_valid(O_valid), .O_ready(O_ready),
    .O_ferr(O_ferr), .O_perr(O_perr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic             i, v, s;
    logic             ev, ef, ep;
    logic [WIDTH-1:0] eo;
  } vec_t;

  vec_t vecs[$];

  // Reference model: received bits kept in a queue, word packed once complete.
  logic             m_bits[$];
  bit               m_hold;
  bit               m_ferr;
  bit               m_perr;
  logic [WIDTH-1:0] m_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic i, input logic v, input logic s, input logic r);
    I = i; I_valid = v; I_start = s; O_ready = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic r);
    for (int k = 0; k < WIDTH; k++) tick(w[k], 1'b1, (k == 0), r);
    if (PAR == 1) tick(^w, 1'b1, 1'b0, r);
  endtask

  task automatic add_row(input logic i, input logic v, input logic s, input logic ev, input logic ef);
    vec_t r;
    r.i = i; r.v = v; r.s = s; r.ev = ev; r.ef = ef; r.ep = 1'b0; r.eo = '0;
    vecs.push_back(r);
  endtask

  // Remaining data bits from index 'from', optional parity bit, then one delivery row.
  task automatic add_tail(input logic [WIDTH-1:0] w, input logic pbit, input int from);
    int last;
    for (int k = from; k < WIDTH; k++) add_row(w[k], 1'b1, (k == 0), 1'b0, 1'b0);
    if (PAR == 1) add_row(pbit, 1'b1, 1'b0, 1'b0, 1'b0);
    last = vecs.size() - 1;
    vecs[last].ev = 1'b1;
    vecs[last].eo = w;
    vecs[last].ep = (PAR == 1) ? ((^w) ^ pbit) : 1'b0;
    add_row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_hold = 0; m_ferr = 0; m_perr = 0; m_word = '0;
  endtask

  task automatic model_finish_word();
    bit p;
    p = 0;
    for (int k = 0; k < WIDTH; k++) m_word[k] = m_bits[k];
    foreach (m_bits[k]) p = p ^ m_bits[k];
    m_perr = (PAR == 1) ? p : 1'b0;
    m_hold = 1;
    m_bits.delete();
  endtask

  task automatic model_step(input logic i, input logic v, input logic s, input logic r);
    m_ferr = 0;
    if (m_hold) begin
      if (r) m_hold = 0;
    end else if (v) begin
      if (s) begin
        if (m_bits.size() > 0) m_ferr = 1;
        if (PAR == 1 && m_bits.size() == WIDTH) begin
          for (int k = 0; k < WIDTH; k++) m_word[k] = m_bits[k];
          m_perr = 1;
          m_hold = 1;
          m_bits.delete();
        end else begin
          m_bits.delete();
          m_bits.push_back(i);
        end
      end else if (m_bits.size() > 0) begin
        m_bits.push_back(i);
        if (m_bits.size() == WIDTH + PAR) model_finish_word();
      end
    end
  endtask

  task automatic compare_model();
    check("rand_O_valid", 32'(O_valid), 32'(m_hold));
    check("rand_I_ready", 32'(I_ready), 32'(!m_hold));
    check("rand_O_ferr", 32'(O_ferr), 32'(m_ferr));
    if (m_hold) begin
      check("rand_O", 32'(O), 32'(m_word));
      check("rand_O_perr", 32'(O_perr), 32'(m_perr));
    end
  endtask

  task automatic release_reset();
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
  endtask

  initial begin
    logic i, v, s, r;
    ASYNCRESETN = 1'b0;
    I = 0; I_valid = 0; I_start = 0; O_ready = 0;
    #12;
    check("reset_O_valid", 32'(O_valid), 32'd0);
    check("reset_I_ready", 32'(I_ready), 32'd1);
    check("reset_O", 32'(O), 32'd0);
    check("reset_O_ferr", 32'(O_ferr), 32'd0);
    check("reset_O_perr", 32'(O_perr), 32'd0);
    release_reset();

    // Plain word, premature start, and idle non-start bits before a word.
    add_tail(8'hA5, 1'b0, 0);
    add_row(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_row(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_row(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    add_tail(8'h3C, 1'b0, 1);
    add_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_row(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_tail(8'h55, 1'b0, 0);
`ifdef SERIAL_WORD_RX_PARITY_EN
    add_tail(8'h0F, 1'b0, 0);
    add_tail(8'h0F, 1'b1, 0);
`endif
    for (int n = 0; n < vecs.size(); n++) begin
      tick(vecs[n].i, vecs[n].v, vecs[n].s, 1'b1);
      check($sformatf("vec%0d_O_valid", n), 32'(O_valid), 32'(vecs[n].ev));
      check($sformatf("vec%0d_I_ready", n), 32'(I_ready), 32'(!vecs[n].ev));
      check($sformatf("vec%0d_O_ferr", n), 32'(O_ferr), 32'(vecs[n].ef));
      if (vecs[n].ev) begin
        check($sformatf("vec%0d_O", n), 32'(O), 32'(vecs[n].eo));
        check($sformatf("vec%0d_O_perr", n), 32'(O_perr), 32'(vecs[n].ep));
      end
    end

    // Back-pressure: word held while O_ready=0, start bits offered meanwhile are ignored.
    send_word(8'hA5, 1'b0);
    check("hold_rise_valid", 32'(O_valid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      check("hold_valid", 32'(O_valid), 32'd1);
      check("hold_O", 32'(O), 32'hA5);
      check("hold_I_ready", 32'(I_ready), 32'd0);
    end
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    check("deliver_valid", 32'(O_valid), 32'd0);
    check("deliver_I_ready", 32'(I_ready), 32'd1);
    for (int k = 1; k < WIDTH + PAR; k++) tick(1'b1, 1'b1, 1'b0, 1'b1);
    check("stall_start_ignored", 32'(O_valid), 32'd0);
    send_word(8'h33, 1'b1);
    check("after_hold_valid", 32'(O_valid), 32'd1);
    check("after_hold_O", 32'(O), 32'h33);
    check("after_hold_ferr", 32'(O_ferr), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset while holding a word, then mid-word.
    send_word(8'h5A, 1'b0);
    check("pre_reset_valid", 32'(O_valid), 32'd1);
    #2 ASYNCRESETN = 1'b0;
    #1;
    check("rst_hold_valid", 32'(O_valid), 32'd0);
    check("rst_hold_I_ready", 32'(I_ready), 32'd1);
    check("rst_hold_O", 32'(O), 32'd0);
    release_reset();
    for (int k = 0; k < 4; k++) tick(k[0], 1'b1, (k == 0), 1'b1);
    #2 ASYNCRESETN = 1'b0;
    #1;
    check("rst_mid_valid", 32'(O_valid), 32'd0);
    check("rst_mid_I_ready", 32'(I_ready), 32'd1);
    check("rst_mid_ferr", 32'(O_ferr), 32'd0);
    release_reset();
    send_word(8'h81, 1'b1);
    check("post_rst_valid", 32'(O_valid), 32'd1);
    check("post_rst_O", 32'(O), 32'h81);
    check("post_rst_perr", 32'(O_perr), 32'd0);

    // Random traffic against the reference model, from a clean reset.
    #2 ASYNCRESETN = 1'b0;
    #1;
    release_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 2);
      i = $urandom_range(0, 1);
      r = ($urandom_range(0, 9) < 6);
      model_step(i, v, s, r);
      tick(i, v, s, r);
      compare_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

- Receiving end of the team's single-bit serial datapath.
- Takes a valid/ready-qualified bit stream, LSB first, with a start marker on bit 0, and assembles it into WIDTH-bit words.
- Presents each completed word on a valid/ready output port and holds it until the consumer accepts it.
- Sits after the combinational bit-producing stages and feeds word-wide sinks.

## Interface

Parameters:
- WIDTH, default 8: bits per word; must be ≥ 2.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- ASYNCRESETN  input  1  reset, asynchronous and active-low.
- I  input  1  serial data bit.
- I_valid  input  1  I carries a bit this cycle.
- I_start  input  1  qualifies I as bit 0 of a new word; only meaningful when I_valid=1.
- I_ready  output  1  block accepts a bit this cycle.
- O  output  WIDTH  assembled word; bit k is the k-th accepted bit.
- O_valid  output  1  O holds a complete word.
- O_ready  input  1  consumer accepts O.
- O_ferr  output  1  one-cycle framing-error pulse.
- O_perr  output  1  parity error flag, qualified by O_valid.

## Operation

- A bit is accepted when I_valid=1 and I_ready=1. I_ready is 1 in IDLE, SHIFT and PARITY, and 0 in HOLD.
- A word is delivered when O_valid=1 and O_ready=1.
- IDLE:
  - An accepted bit with I_start=1 writes O[0]=I, sets cnt=1 and moves to SHIFT.
  - An accepted bit with I_start=0 is discarded; no error is flagged.
- SHIFT:
  - An accepted bit with I_start=0 writes O[cnt]=I and increments cnt.
  - When cnt reaches WIDTH, the state moves to PARITY if the parity feature is compiled in, otherwise to HOLD.
  - An accepted bit with I_start=1 (premature start) pulses O_ferr for one cycle, discards the partial word, writes O[0]=I, sets cnt=1 and stays in SHIFT.
- PARITY (feature builds only):
  - The next accepted bit is the parity bit.
  - O_perr is set to (XOR of O) XOR I, giving even parity over word plus parity bit. The state moves to HOLD.
  - If the accepted bit has I_start=1, O_ferr pulses, O_perr is set to 1 and the state moves to HOLD. The start bit is consumed, not re-used.
- HOLD:
  - O_valid=1; O and O_perr are stable.
  - On O_ready=1 the state moves to IDLE the next cycle.
  - Input is stalled in HOLD (I_ready=0). A start bit presented in the delivery cycle is accepted in the following cycle, in IDLE.
- cnt is $clog2(WIDTH+1) bits wide and never exceeds WIDTH.
- Bits of O not yet written in the current word are unspecified until O_valid=1.

## Timing

- Reset values (asynchronous, while ASYNCRESETN=0):
  - state=IDLE, cnt=0, O=0, O_valid=0, O_ferr=0, O_perr=0, I_ready=1.
  - Release is synchronous to CLK by the integrator.
- Latency: O_valid rises the cycle after the last data bit is accepted (no-parity build) or after the parity bit is accepted (parity build).
- Minimum word period:
  - WIDTH+1 cycles per word without parity, WIDTH+2 with parity, when O_ready is held high.
  - The extra cycle is HOLD.
- O_ferr is registered and high exactly one cycle, the cycle after the offending bit is accepted.
- Reset asserted mid-word or in HOLD: the partial or held word is discarded immediately and O_valid drops asynchronously.
- I_valid, I_start and I are ignored while I_ready=0.

## Configuration

- Macro: SERIAL_WORD_RX_PARITY_EN.
- Defined:
  - PARITY state present.
  - Each word is followed by one even-parity bit.
  - O_perr reports a mismatch alongside O_valid.
- Undefined:
  - No PARITY state; SHIFT goes directly to HOLD.
  - O_perr is tied to 0.
  - Word period is WIDTH+1 cycles.

## Test plan

1. No-parity build, WIDTH=8: start + bits LSB-first of 0xA5 at I_valid=1 every cycle, O_ready=1 -> O=0xA5, O_valid high for one cycle, the cycle after bit 7; O_ferr=0.
2. Same stream with O_ready=0 for 5 cycles after O_valid rises -> O_valid and O=0xA5 held 5 cycles; I_ready=0 throughout; a start bit offered there is not accepted until IDLE.
3. Start, bits 1,1,0, then I_start=1 with I=0, then 7 more bits forming 0x3C -> O_ferr one-cycle pulse after the 4th accepted bit; delivered O=0x3C.
4. Parity build: 0x0F plus parity 0 -> O=0x0F, O_perr=0. Then 0x0F plus parity 1 -> O_perr=1 with O_valid.
5. Assert ASYNCRESETN=0 between clock edges after 4 bits of a word -> O_valid=0, I_ready=1 immediately. After release, a fresh 0x81 word is delivered correctly.
6. Bits with I_start=0 in IDLE, 3 cycles, then a valid word 0x55 -> first 3 bits discarded, no O_ferr, O=0x55.
